// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute controller for the 8-bit
// computer. It owns the program counter and instruction register, talks to the
// shared program/data memory over a req/ack handshake, and strobes the
// accumulator load with the ALU operation for LDA/ADD/SUB.
module instr_sequencer #(
  parameter int PC_W    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  input  logic [7:0]      mem_rdata,
  input  logic            mem_ack,
  input  logic            zero_flag,
  output logic            acc_we,
  output logic [1:0]      alu_op,
  output logic [7:0]      ir,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            err
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_STA = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_JZ  = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // The counter holds the number of unacknowledged request cycles already
  // spent; the request cycle that would make it reach TIMEOUT is the last one.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC_RD = 3'd3,
    S_EXEC_WR = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [7:0]      ir_nx;
  logic            err_nx;
  logic [7:0]      tcnt;
  logic [7:0]      tcnt_nx;

  logic [2:0]      opcode;
  logic [PC_W-1:0] operand;
  logic            to_hit;

  assign opcode  = ir[7:5];
  assign operand = ir[PC_W-1:0];
  assign to_hit  = (tcnt == TO_LAST);

  // ALU operation selected by the instruction that is loading the accumulator.
  function automatic logic [1:0] alu_sel(input logic [2:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      default: return ALU_PASS;
    endcase
  endfunction

  // State, program counter, instruction register, error flag and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      err   <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      err   <= err_nx;
      tcnt  <= tcnt_nx;
    end
  end

  // Next-state sequencing, handshake outputs and datapath strobes.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir;
    err_nx   = err;
    tcnt_nx  = '0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    acc_we   = 1'b0;
    alu_op   = ALU_PASS;
    halted   = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) state_nx = S_FETCH;
      end

      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          ir_nx    = mem_rdata;
          pc_nx    = pc + PC_W'(1);
          state_nx = S_DECODE;
        end else if (to_hit) begin
          err_nx   = 1'b1;
          state_nx = S_HALT;
        end else begin
          tcnt_nx  = tcnt + 8'd1;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_NOP: state_nx = S_FETCH;
          OP_LDA: state_nx = S_EXEC_RD;
          OP_STA: state_nx = S_EXEC_WR;
          OP_ADD: state_nx = S_EXEC_RD;
          OP_SUB: state_nx = S_EXEC_RD;
          OP_JMP: begin
            pc_nx    = operand;
            state_nx = S_FETCH;
          end
          OP_JZ: begin
            if (zero_flag) pc_nx = operand;
            state_nx = S_FETCH;
          end
          OP_HLT: state_nx = S_HALT;
        endcase
      end

      S_EXEC_RD: begin
        mem_req  = 1'b1;
        mem_addr = operand;
        if (mem_ack) begin
          // The datapath captures mem_rdata on the same edge as the ack.
          acc_we   = 1'b1;
          alu_op   = alu_sel(opcode);
          state_nx = S_FETCH;
        end else if (to_hit) begin
          err_nx   = 1'b1;
          state_nx = S_HALT;
        end else begin
          tcnt_nx  = tcnt + 8'd1;
        end
      end

      S_EXEC_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = operand;
        if (mem_ack) begin
          state_nx = S_FETCH;
        end else if (to_hit) begin
          err_nx   = 1'b1;
          state_nx = S_HALT;
        end else begin
          tcnt_nx  = tcnt + 8'd1;
        end
      end

      S_HALT: begin
        halted = 1'b1;
        // A memory timeout locks the sequencer here until reset.
        if (run && !err) state_nx = S_FETCH;
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed scenarios followed by a random
// program run checked against an instruction-level model of the machine.
module tb_instr_sequencer;

  localparam int PC_W    = 5;
  localparam int TIMEOUT = 15;

  localparam int K_FETCH = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;
  localparam int K_HALT  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic            mem_req;
  logic            mem_we;
  logic [PC_W-1:0] mem_addr;
  logic [7:0]      mem_rdata;
  logic            mem_ack;
  logic            zero_flag;
  logic            acc_we;
  logic [1:0]      alu_op;
  logic [7:0]      ir;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic            err;

  // Memory responder controls
  logic [7:0] mem [32];
  int         wait_cnt   = 0;
  int         lat        = 0;
  int         lat_fixed  = 0;
  bit         lat_rand   = 1'b0;
  bit         never_ack  = 1'b0;
  bit         mem_auto   = 1'b1;
  logic       auto_ack   = 1'b0;
  logic [7:0] auto_rdata = 8'h00;
  logic       man_ack    = 1'b0;
  logic [7:0] man_rdata  = 8'h00;

  // Datapath stand-in
  logic [7:0] acc = 8'h00;
  bit         zf_auto  = 1'b0;
  bit         zf_force = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;
    int addr;
    int op;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] model_mem [32];
  logic [4:0] mpc;
  logic [7:0] macc;
  int         instr_cnt;

  assign mem_ack   = mem_auto ? auto_ack : man_ack;
  assign mem_rdata = mem_auto ? auto_rdata : man_rdata;
  assign zero_flag = zf_auto ? (acc == 8'd0) : zf_force;

  instr_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .zero_flag(zero_flag),
    .acc_we(acc_we), .alu_op(alu_op), .ir(ir), .pc(pc),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int pick_lat();
    if (lat_rand) return int'($urandom_range(0, 3));
    return lat_fixed;
  endfunction

  // Memory: acks after 'lat' waiting cycles; junk data outside ack cycles.
  always @(negedge clk) begin
    if (mem_req !== 1'b1) begin
      wait_cnt   = 0;
      auto_ack   = 1'b0;
      auto_rdata = 8'($urandom);
      lat        = pick_lat();
    end else if (!never_ack && wait_cnt >= lat) begin
      auto_ack   = 1'b1;
      auto_rdata = mem[mem_addr];
      wait_cnt   = 0;
      lat        = pick_lat();
    end else begin
      auto_ack   = 1'b0;
      auto_rdata = 8'($urandom);
      wait_cnt++;
    end
  end

  // Accumulator and memory write port driven by the sequencer's strobes.
  always @(posedge clk) begin
    if (rst) begin
      acc <= 8'h00;
    end else if (acc_we) begin
      case (alu_op)
        2'b00:   acc <= mem_rdata;
        2'b01:   acc <= acc + mem_rdata;
        2'b10:   acc <= acc - mem_rdata;
        default: acc <= 8'hxx;
      endcase
    end
    if (mem_req && mem_we && mem_ack) mem[mem_addr] <= acc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic push_ev(input int kind, input int addr, input int op);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.op   = op;
    evq.push_back(e);
  endtask

  // Executes one instruction of the ISA and lists the bus activity it implies.
  task automatic model_step();
    logic [7:0] ins;
    logic [4:0] opd;
    ins = model_mem[mpc];
    opd = ins[4:0];
    push_ev(K_FETCH, int'(mpc), 0);
    mpc = mpc + 5'd1;
    case (ins[7:5])
      3'd1: begin push_ev(K_READ, int'(opd), 0); macc = model_mem[opd]; end
      3'd2: begin push_ev(K_WRITE, int'(opd), 0); model_mem[opd] = macc; end
      3'd3: begin push_ev(K_READ, int'(opd), 1); macc = macc + model_mem[opd]; end
      3'd4: begin push_ev(K_READ, int'(opd), 2); macc = macc - model_mem[opd]; end
      3'd5: mpc = opd;
      3'd6: if (macc == 8'd0) mpc = opd;
      3'd7: push_ev(K_HALT, 0, 0);
      default: ;
    endcase
    instr_cnt++;
  endtask

  initial begin
    int   n_str;
    int   str_c [4];
    int   str_op [4];
    int   first_halt;
    int   req_seen;
    ev_t  hd;

    rst = 1'b1;
    run = 1'b0;
    clear_mem();

    // Reset state
    do_reset();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_acc_we", 32'(acc_we), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    tick();
    check("idle_no_run_req", 32'(mem_req), 32'd0);

    // LDA 3 / ADD 4 / HLT with zero-wait memory
    clear_mem();
    mem[0] = 8'h23; mem[1] = 8'h64; mem[2] = 8'hE0; mem[3] = 8'h05; mem[4] = 8'h07;
    lat_fixed = 0;
    do_reset();
    run = 1'b1;
    n_str = 0;
    first_halt = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) run = 1'b0;
      if (acc_we === 1'b1) begin
        if (n_str < 4) begin
          str_c[n_str]  = c;
          str_op[n_str] = int'(alu_op);
        end
        n_str++;
      end
      if (halted === 1'b1 && first_halt == 0) first_halt = c;
    end
    check("prog_strobes", 32'(n_str), 32'd2);
    check("prog_lda_cycle", 32'(str_c[0]), 32'd3);
    check("prog_lda_op", 32'(str_op[0]), 32'd0);
    check("prog_add_cycle", 32'(str_c[1]), 32'd6);
    check("prog_add_op", 32'(str_op[1]), 32'd1);
    check("prog_halt_cycle", 32'(first_halt), 32'd9);
    check("prog_halt_held", 32'(halted), 32'd1);
    check("prog_pc", 32'(pc), 32'd3);
    check("prog_acc", 32'(acc), 32'd12);
    check("prog_err", 32'(err), 32'd0);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("resume_req", 32'(mem_req), 32'd1);
    check("resume_addr", 32'(mem_addr), 32'd3);
    check("resume_halted", 32'(halted), 32'd0);

    // STA 5 with a memory that acks on the third request cycle
    clear_mem();
    mem[0] = 8'h45; mem[1] = 8'hE0;
    lat_fixed = 2;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) run = 1'b0;
      if (c == 4) check("sta_decode_req", 32'(mem_req), 32'd0);
      if (c >= 5 && c <= 7) begin
        check("sta_req", 32'(mem_req), 32'd1);
        check("sta_we", 32'(mem_we), 32'd1);
        check("sta_addr", 32'(mem_addr), 32'd5);
        check("sta_ack", 32'(mem_ack), (c == 7) ? 32'd1 : 32'd0);
      end
      if (c == 8) begin
        check("sta_next_req", 32'(mem_req), 32'd1);
        check("sta_next_we", 32'(mem_we), 32'd0);
        check("sta_next_addr", 32'(mem_addr), 32'd1);
      end
    end
    lat_fixed = 0;

    // JZ 16 with zero_flag set and clear
    for (int z = 0; z < 2; z++) begin
      clear_mem();
      mem[0] = 8'hD0;
      zf_force = (z == 0);
      do_reset();
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
      check("jz_decode_req", 32'(mem_req), 32'd0);
      tick();
      check("jz_fetch_req", 32'(mem_req), 32'd1);
      check("jz_fetch_addr", 32'(mem_addr), (z == 0) ? 32'd16 : 32'd1);
    end
    zf_force = 1'b0;

    // JMP 31 then NOP at 31: the program counter wraps to 0
    clear_mem();
    mem[0] = 8'hBF; mem[31] = 8'h00;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    check("wrap_fetch31", 32'(mem_addr), 32'd31);
    tick();
    check("wrap_pc", 32'(pc), 32'd0);
    tick();
    check("wrap_req", 32'(mem_req), 32'd1);
    check("wrap_addr", 32'(mem_addr), 32'd0);

    // Memory never acks: timeout halts with err set
    never_ack = 1'b1;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) run = 1'b0;
      if (c == 15) begin
        check("to_last_req", 32'(mem_req), 32'd1);
        check("to_last_err", 32'(err), 32'd0);
        check("to_last_halted", 32'(halted), 32'd0);
      end
      if (c == 16) begin
        check("to_err", 32'(err), 32'd1);
        check("to_halted", 32'(halted), 32'd1);
        check("to_req_dropped", 32'(mem_req), 32'd0);
      end
    end
    run = 1'b1;
    req_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_req !== 1'b0) req_seen++;
    end
    check("to_run_blocked_req", 32'(req_seen), 32'd0);
    check("to_run_still_halted", 32'(halted), 32'd1);
    run = 1'b0;
    never_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("to_rst_err", 32'(err), 32'd0);
    check("to_rst_pc", 32'(pc), 32'd0);
    check("to_rst_halted", 32'(halted), 32'd0);

    // Ack in the request cycle that would have timed out: ack wins
    clear_mem();
    mem[0] = 8'h1A;
    lat_fixed = 14;
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) run = 1'b0;
      if (c == 15) check("ackwin_ack", 32'(mem_ack), 32'd1);
    end
    check("ackwin_err", 32'(err), 32'd0);
    check("ackwin_halted", 32'(halted), 32'd0);
    check("ackwin_req", 32'(mem_req), 32'd0);
    check("ackwin_ir", 32'(ir), 32'h1A);
    check("ackwin_pc", 32'(pc), 32'd1);
    lat_fixed = 0;

    // Reset during an EXEC_RD wait, late ack afterwards
    clear_mem();
    mem[0] = 8'h23; mem[3] = 8'h55;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    never_ack = 1'b1;
    tick();
    check("mid_rd_req", 32'(mem_req), 32'd1);
    check("mid_rd_addr", 32'(mem_addr), 32'd3);
    check("mid_rd_acc_we", 32'(acc_we), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_ir", 32'(ir), 32'd0);
    mem_auto  = 1'b0;
    man_ack   = 1'b1;
    man_rdata = 8'h55;
    rst = 1'b0;
    #1;
    check("late_ack_acc_we", 32'(acc_we), 32'd0);
    tick();
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_halted", 32'(halted), 32'd0);
    check("late_ack_pc", 32'(pc), 32'd0);
    check("late_ack_ir", 32'(ir), 32'd0);
    check("late_ack_acc", 32'(acc), 32'd0);
    man_ack   = 1'b0;
    mem_auto  = 1'b1;
    never_ack = 1'b0;

    // Random program, random latency, run held high
    for (int i = 0; i < 32; i++) begin
      mem[i]       = 8'($urandom);
      model_mem[i] = mem[i];
    end
    lat_rand  = 1'b1;
    zf_auto   = 1'b1;
    mpc       = 5'd0;
    macc      = 8'd0;
    instr_cnt = 0;
    evq.delete();
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (evq.size() == 0) model_step();
      hd = evq[0];
      if (mem_req === 1'b1) begin
        check("rnd_req_kind", 32'(mem_req), 32'(hd.kind != K_HALT));
        check("rnd_addr", 32'(mem_addr), 32'(hd.addr));
        check("rnd_we", 32'(mem_we), 32'(hd.kind == K_WRITE));
        if (mem_ack === 1'b1) begin
          check("rnd_acc_we", 32'(acc_we), 32'(hd.kind == K_READ));
          if (hd.kind == K_READ) check("rnd_alu_op", 32'(alu_op), 32'(hd.op));
          void'(evq.pop_front());
        end else begin
          check("rnd_wait_acc_we", 32'(acc_we), 32'd0);
        end
      end else if (halted === 1'b1) begin
        check("rnd_halt", 32'(hd.kind), 32'(K_HALT));
        void'(evq.pop_front());
      end else begin
        check("rnd_quiet_acc_we", 32'(acc_we), 32'd0);
        check("rnd_quiet_alu_op", 32'(alu_op), 32'd0);
      end
    end
    run = 1'b0;
    check("rnd_err", 32'(err), 32'd0);
    check("rnd_progress", 32'(instr_cnt > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
